// File: rtl/display_scan_mux.sv
// Scan multiplexer for a 4-digit active-low 7-segment display. It steps one digit per
// counter-bit rising edge, blanks between digits, suppresses leading zeros and latches per frame.
module display_scan_mux #(
    parameter int unsigned SCAN_BIT      = 17,
    parameter int unsigned BLANK_CYCLES  = 1024,
    parameter bit          ZERO_SUPPRESS = 1'b1
) (
    input  logic        clk_internal,
    input  logic        reset_n,
    input  logic [17:0] clk_divided,
    input  logic        enable,
    input  logic [15:0] digits_bcd,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned     CntW    = $clog2(BLANK_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [6:0]      SegOff  = 7'h7F;

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e          state_q;
    logic [1:0]      index_q;
    logic [CntW-1:0] blank_cnt_q;
    logic [15:0]     snap_digits_q;
    logic [3:0]      snap_dp_q;
    logic            prev_q;

    logic            tick;
    logic [3:0]      cur_digit;
    logic [3:0]      lead_zero;
    logic            suppress;
    logic [6:0]      show_seg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // The counter wrap to zero is a falling edge, so it never produces a tick.
    assign tick = clk_divided[SCAN_BIT] & ~prev_q;

    always_comb begin
        cur_digit    = snap_digits_q[{index_q, 2'b00} +: 4];
        // lead_zero[i]: digit i and every digit above it are zero; digit 0 is never blanked.
        lead_zero[3] = (snap_digits_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] & (snap_digits_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] & (snap_digits_q[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        suppress     = ZERO_SUPPRESS & lead_zero[index_q];
        show_seg     = suppress ? SegOff : decode(cur_digit);
    end

    always_ff @(posedge clk_internal) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            index_q       <= 2'd0;
            blank_cnt_q   <= '0;
            snap_digits_q <= 16'h0000;
            snap_dp_q     <= 4'h0;
            prev_q        <= 1'b0;
            seg           <= SegOff;
            dp            <= 1'b1;
            digit_sel     <= 4'hF;
            frame_done    <= 1'b0;
        end else begin
            prev_q     <= clk_divided[SCAN_BIT];
            frame_done <= 1'b0;

            // Outputs follow the state of the previous cycle.
            if (state_q == StShow) begin
                seg       <= show_seg;
                dp        <= ~snap_dp_q[index_q];
                digit_sel <= ~(4'b0001 << index_q);
            end else begin
                seg       <= SegOff;
                dp        <= 1'b1;
                digit_sel <= 4'hF;
            end

            if (!enable) begin
                state_q <= StIdle;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q       <= StBlank;
                        index_q       <= 2'd0;
                        blank_cnt_q   <= '0;
                        snap_digits_q <= digits_bcd;
                        snap_dp_q     <= dp_mask;
                        frame_done    <= 1'b1;
                    end
                    StBlank: begin
                        if (blank_cnt_q == CntLast) begin
                            state_q <= StShow;
                        end else begin
                            blank_cnt_q <= blank_cnt_q + CntW'(1);
                        end
                    end
                    StShow: begin
                        if (tick) begin
                            state_q     <= StBlank;
                            blank_cnt_q <= '0;
                            index_q     <= index_q + 2'd1;
                            if (index_q == 2'd3) begin
                                snap_digits_q <= digits_bcd;
                                snap_dp_q     <= dp_mask;
                                frame_done    <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: a cycle model of the scan rules is checked every cycle,
// and hand-decoded digit values are checked at chosen points.
module tb_display_scan_mux;

    localparam int unsigned BLANK = 8;

    logic        clk_internal = 1'b0;
    logic        reset_n;
    logic [17:0] clk_divided;
    logic        enable;
    logic [15:0] digits_bcd;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  digit_sel;
    logic        frame_done;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    display_scan_mux #(
        .SCAN_BIT     (17),
        .BLANK_CYCLES (BLANK),
        .ZERO_SUPPRESS(1'b1)
    ) dut (
        .clk_internal(clk_internal),
        .reset_n     (reset_n),
        .clk_divided (clk_divided),
        .enable      (enable),
        .digits_bcd  (digits_bcd),
        .dp_mask     (dp_mask),
        .seg         (seg),
        .dp          (dp),
        .digit_sel   (digit_sel),
        .frame_done  (frame_done)
    );

    always #5 clk_internal = ~clk_internal;

    // Model: mode 0 = dark/idle, 1 = blanking gap, 2 = showing digit m_idx.
    logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    int         m_mode, m_idx, m_left;
    int         m_dig [4];
    logic [3:0] m_dp;
    logic       m_prev;
    bit         m_valid = 1'b0;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_sel;
    logic       e_fd;

    task automatic grab_frame();
        for (int i = 0; i < 4; i++) m_dig[i] = int'((digits_bcd >> (4 * i)) & 16'hF);
        m_dp = dp_mask;
    endtask

    always @(posedge clk_internal) begin
        bit tk;
        int lead;
        if (!reset_n) begin
            m_mode = 0; m_idx = 0; m_left = 0; m_prev = 1'b0;
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_dp = 4'h0;
            e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF; e_fd = 1'b0;
            m_valid = 1'b1;
        end else begin
            if (m_mode == 2) begin
                lead = 0;
                for (int i = 0; i < 4; i++) if (m_dig[i] != 0) lead = i;
                e_sel = ~(4'b0001 << m_idx);
                e_seg = (m_idx > lead) ? 7'h7F : seg_tab[m_dig[m_idx]];
                e_dp  = ~m_dp[m_idx];
            end else begin
                e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF;
            end
            tk = clk_divided[17] && !m_prev;
            m_prev = clk_divided[17];
            e_fd = 1'b0;
            if (!enable) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1; m_left = BLANK; m_idx = 0; grab_frame(); e_fd = 1'b1;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end else if (tk) begin
                m_idx = (m_idx + 1) % 4; m_mode = 1; m_left = BLANK;
                if (m_idx == 0) begin
                    grab_frame(); e_fd = 1'b1;
                end
            end
        end
    end

    always @(negedge clk_internal) begin
        if (m_valid) begin
            checks++;
            if ({seg, dp, digit_sel, frame_done} !== {e_seg, e_dp, e_sel, e_fd}) begin
                failures++;
                $display("FAIL model t=%0t: got seg=%h dp=%b sel=%h fd=%b, want seg=%h dp=%b sel=%h fd=%b",
                         $time, seg, dp, digit_sel, frame_done, e_seg, e_dp, e_sel, e_fd);
            end
        end
    end

    task automatic lit(input string name, input logic [3:0] sel, input logic [6:0] s,
                       input logic d);
        checks++;
        if (digit_sel !== sel || seg !== s || dp !== d) begin
            failures++;
            $display("FAIL %s: got sel=%h seg=%h dp=%b, want sel=%h seg=%h dp=%b",
                     name, digit_sel, seg, dp, sel, s, d);
        end
    endtask

    task automatic lit_fd(input string name, input logic want);
        checks++;
        if (frame_done !== want) begin
            failures++;
            $display("FAIL %s: got frame_done=%b, want %b", name, frame_done, want);
        end
    endtask

    // One scan tick, then wait until the next digit is on the outputs.
    task automatic step();
        @(negedge clk_internal);
        clk_divided = 18'h20000;
        repeat (2) @(negedge clk_internal);
        clk_divided = 18'h00000;
        repeat (BLANK + 4) @(negedge clk_internal);
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; clk_divided = 18'h0;
        digits_bcd = 16'h0042; dp_mask = 4'h0;
        repeat (3) @(negedge clk_internal);
        lit("reset_outputs", 4'hF, 7'h7F, 1'b1);
        lit_fd("reset_fd", 1'b0);
        reset_n = 1'b1;
        @(negedge clk_internal);
        lit_fd("first_frame_fd", 1'b1);
        repeat (BLANK + 3) @(negedge clk_internal);
        lit("0042_d0", 4'hE, 7'h24, 1'b1);
        step(); lit("0042_d1", 4'hD, 7'h19, 1'b1);
        step(); lit("0042_d2", 4'hB, 7'h7F, 1'b1);
        step(); lit("0042_d3", 4'h7, 7'h7F, 1'b1);
        digits_bcd = 16'h0000;
        step(); lit("0000_d0", 4'hE, 7'h40, 1'b1);
        step(); lit("0000_d1", 4'hD, 7'h7F, 1'b1);
        step();
        digits_bcd = 16'h0A05; dp_mask = 4'b0100;
        step(); lit("0000_d3", 4'h7, 7'h7F, 1'b1);
        step(); lit("0A05_d0", 4'hE, 7'h12, 1'b1);
        step(); lit("0A05_d1", 4'hD, 7'h40, 1'b1);
        step(); lit("0A05_d2", 4'hB, 7'h3F, 1'b0);
        step(); lit("0A05_d3", 4'h7, 7'h7F, 1'b1);
        digits_bcd = 16'h1234; dp_mask = 4'h0;
        step(); lit("1234_d0", 4'hE, 7'h19, 1'b1);
        step(); lit("1234_d1", 4'hD, 7'h30, 1'b1);
        step(); lit("1234_d2", 4'hB, 7'h24, 1'b1);
        digits_bcd = 16'h5678;
        step(); lit("tear_d3", 4'h7, 7'h79, 1'b1);
        step(); lit("5678_d0", 4'hE, 7'h00, 1'b1);
        step(); lit("5678_d1", 4'hD, 7'h78, 1'b1);
        step(); lit("5678_d2", 4'hB, 7'h02, 1'b1);
        step(); lit("5678_d3", 4'h7, 7'h12, 1'b1);
        // Counter reaches 3FFFF (a tick) and then wraps to 0 (not a tick).
        @(negedge clk_internal);
        clk_divided = 18'h3FFFF;
        repeat (BLANK + 6) @(negedge clk_internal);
        lit("pre_wrap", 4'hE, 7'h00, 1'b1);
        clk_divided = 18'h00000;
        repeat (5) @(negedge clk_internal);
        lit("post_wrap", 4'hE, 7'h00, 1'b1);
        enable = 1'b0;
        repeat (2) @(negedge clk_internal);
        lit("enable_off", 4'hF, 7'h7F, 1'b1);
        repeat (3) @(negedge clk_internal);
        enable = 1'b1;
        @(negedge clk_internal);
        lit_fd("reenable_fd", 1'b1);
        repeat (BLANK + 3) @(negedge clk_internal);
        lit("reenable_d0", 4'hE, 7'h00, 1'b1);
        step(); lit("pre_reset_d1", 4'hD, 7'h78, 1'b1);
        reset_n = 1'b0;
        @(negedge clk_internal);
        lit("mid_reset", 4'hF, 7'h7F, 1'b1);
        lit_fd("mid_reset_fd", 1'b0);
        reset_n = 1'b1;
        @(negedge clk_internal);
        lit_fd("restart_fd", 1'b1);
        repeat (BLANK + 3) @(negedge clk_internal);
        lit("restart_d0", 4'hE, 7'h00, 1'b1);
        repeat (2) @(negedge clk_internal);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Consumer of the free-running 18-bit divided counter (clk_divided, 50 MHz base).
- Drives a 4-digit multiplexed 7-segment display showing parking-slot figures (free/occupied counts as BCD).
- Converts rising edges of one counter bit into digit-scan ticks, inserts an anti-ghosting blank between digits, suppresses leading zeros and latches the displayed value once per frame so it cannot tear.

Parameters:
- SCAN_BIT, 17, index of the clk_divided bit whose rising edge advances the scan; bit 17 gives ~190 Hz per digit step.
- BLANK_CYCLES, 1024, clk_internal cycles with all digits off after each advance; legal range 1 .. 2^SCAN_BIT-2.
- ZERO_SUPPRESS, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits.

Ports:
- clk_internal  input  1  system clock, 50 MHz.
- reset_n  input  1  synchronous reset, active-low.
- clk_divided  input  18  free-running divided counter.
- enable  input  1  1 = scan display; 0 = all digits dark.
- digits_bcd  input  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- dp_mask  input  4  decimal point request per digit, 1 = lit.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- digit_sel  output  4  digit enables, active-low, one-hot-cold; bit i = digit i.
- frame_done  output  1  one-cycle pulse when a new frame snapshot is latched.

Behaviour:
- Reset is synchronous and active-low: reset_n low on a clk_internal rising edge sets the following.
  - state IDLE, index 0, snapshot 0.
  - seg = 7'h7F, dp = 1, digit_sel = 4'hF, frame_done = 0.
  - Edge-detect register cleared to 0.
- Tick: register prev = clk_divided[SCAN_BIT]; tick = clk_divided[SCAN_BIT] & ~prev.
  - The counter wrap 3FFFF -> 0 is a falling edge and is not a tick.
- States: IDLE, BLANK, SHOW.
  - IDLE: outputs dark. If enable = 1 -> BLANK with index 0, snapshot latch, frame_done pulse.
  - BLANK: outputs dark; counts BLANK_CYCLES cycles, then -> SHOW. Ticks arriving in BLANK are ignored.
  - SHOW: drives digit[index]. On tick -> BLANK with index = (index+1) mod 4.
    - When the new index is 0, latch snapshot and pulse frame_done.
  - In any state, enable = 0 -> IDLE on the next edge, outputs dark on the edge after.
- Snapshot: digits_bcd and dp_mask are captured together. The display uses only the snapshot, so input changes mid-frame appear at the next frame.
- All outputs are registered: seg/dp/digit_sel reflect the state/index one cycle after the transition.
- Decode (active-low) for values 0-9:
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19
  - 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10
  - BCD A-F = dash (3F); blank = 7F.
- Zero suppression (ZERO_SUPPRESS = 1):
  - Digit i (i = 3..1) is blank if it and every higher digit are 0.
  - Digit 0 is always shown.
  - Invalid BCD counts as non-zero, so it stops suppression.
- Blanked digit: digit_sel still selects it, seg = 7F. dp still follows the snapshot mask.
- During SHOW, digit_sel has exactly one bit low. During IDLE/BLANK, digit_sel = F.
- Reset mid-scan: all outputs return to reset values on the next edge; scan restarts at index 0.

Test Plan:
- Reset with enable = 1, bench pulses clk_divided[17] -> after BLANK_CYCLES: digit_sel cycles E, D, B, 7, E with BLANK (F) between each; frame_done pulses once per 4 ticks.
- digits_bcd = 16'h0042 -> digit 3 = 7F, digit 2 = 7F, digit 1 = 19, digit 0 = 24; 16'h0000 -> only digit 0 shows 40.
- digits_bcd = 16'h0A05, dp_mask = 4'b0100 -> digit 3 blank, digit 2 = 3F with dp = 0, digit 1 = 40, digit 0 = 12.
- digits_bcd changed from 1234 to 5678 while index = 2 -> digits 2, 3 still show 2, 1; next frame shows 8, 7, 6, 5.
- clk_divided stepped 3FFFF -> 0 -> no tick, no index change; enable dropped in SHOW -> digit_sel = F and seg = 7F within 2 cycles.
- reset_n low for one cycle mid-SHOW -> outputs return to reset values next edge; scan restarts at index 0 with frame_done pulse.
